// File: rtl/timed_assign_seq.sv
// timed_assign_seq: four-step timed write of a,b,c,d (driven on w,x,y,z) with start/busy/done handshake.
// Define SEQ_ABORT_EN to add an abort input that cancels a running sequence.
module timed_assign_seq #(
    parameter int   CW    = 8,
    parameter int   D_B   = 10,
    parameter int   D_C   = 5,
    parameter int   D_D   = 20,
    parameter logic VAL_A = 1'b0,
    parameter logic VAL_B = 1'b1,
    parameter logic VAL_C = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
`ifdef SEQ_ABORT_EN
    input  logic       abort,
`endif
    output logic       w,
    output logic       x,
    output logic       y,
    output logic [2:0] z,
    output logic       busy,
    output logic       done
);

    if (D_B < 1 || D_B > 2**CW - 1 || D_C < 1 || D_C > 2**CW - 1 ||
        D_D < 1 || D_D > 2**CW - 1) begin : g_bad_delay
        $error("timed_assign_seq: every delay must lie in 1..2**CW-1");
    end

    localparam logic [CW-1:0] CNT_B = CW'(D_B - 1);
    localparam logic [CW-1:0] CNT_C = CW'(D_C - 1);
    localparam logic [CW-1:0] CNT_D = CW'(D_D - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_B,
        WAIT_C,
        WAIT_D
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic          hold, hold_d;
    logic [2:0]    zhold, zhold_d;
    logic          w_d, x_d, y_d;
    logic [2:0]    z_d;
    logic          busy_d, done_d;
    logic          abort_in;

`ifdef SEQ_ABORT_EN
    assign abort_in = abort;
`else
    assign abort_in = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt     <= '0;
            hold    <= 1'b0;
            zhold   <= 3'b000;
            w       <= 1'b1;
            x       <= 1'b0;
            y       <= 1'b1;
            z       <= 3'b000;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt     <= cnt_d;
            hold    <= hold_d;
            zhold   <= zhold_d;
            w       <= w_d;
            x       <= x_d;
            y       <= y_d;
            z       <= z_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt;
        hold_d  = hold;
        zhold_d = zhold;
        w_d     = w;
        x_d     = x;
        y_d     = y;
        z_d     = z;
        busy_d  = busy;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !abort_in) begin
                    w_d     = VAL_A;
                    hold_d  = VAL_B;
                    cnt_d   = CNT_B;
                    busy_d  = 1'b1;
                    state_d = WAIT_B;
                end
            end
            WAIT_B: begin
                if (cnt != '0) begin
                    cnt_d = cnt - CW'(1);
                end else begin
                    x_d     = hold;
                    hold_d  = VAL_C;
                    cnt_d   = CNT_C;
                    state_d = WAIT_C;
                end
            end
            WAIT_C: begin
                if (cnt != '0) begin
                    cnt_d = cnt - CW'(1);
                end else begin
                    y_d     = hold;
                    // d samples a,b,c as they stand after this edge's commit
                    zhold_d = {w, x, hold};
                    cnt_d   = CNT_D;
                    state_d = WAIT_D;
                end
            end
            WAIT_D: begin
                if (cnt != '0) begin
                    cnt_d = cnt - CW'(1);
                end else begin
                    z_d     = zhold;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // abort cancels any commit scheduled on the same edge
        if (abort_in && state_q != IDLE) begin
            cnt_d   = '0;
            hold_d  = hold;
            zhold_d = zhold;
            w_d     = w;
            x_d     = x;
            y_d     = y;
            z_d     = z;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            state_d = IDLE;
        end
    end

endmodule

// File: tb/tb_timed_assign_seq.sv
// Bench for timed_assign_seq: directed timelines plus randomized start/rst against a timeline model.
// Two instances: default delays, and all delays set to 1.
module tb_timed_assign_seq;

    logic clk, rst, start, abort_s;
    logic aw, ax, ay, abusy, adone;
    logic bw, bx, by, bbusy, bdone;
    logic [2:0] az, bz;

    int checks = 0;
    int failures = 0;
    int n = 0;
    bit model_ok = 0;

    localparam int DB [2] = '{10, 1};
    localparam int DC [2] = '{5, 1};
    localparam int DD [2] = '{20, 1};
    localparam logic VA = 1'b0, VB = 1'b1, VC = 1'b0;

    timed_assign_seq dut_a (
        .clk(clk), .rst(rst), .start(start),
`ifdef SEQ_ABORT_EN
        .abort(abort_s),
`endif
        .w(aw), .x(ax), .y(ay), .z(az), .busy(abusy), .done(adone)
    );

    timed_assign_seq #(.D_B(1), .D_C(1), .D_D(1)) dut_b (
        .clk(clk), .rst(rst), .start(start),
`ifdef SEQ_ABORT_EN
        .abort(abort_s),
`endif
        .w(bw), .x(bx), .y(by), .z(bz), .busy(bbusy), .done(bdone)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at edge %0d", nm, act, exp, n);
        end
    endtask

    // Model: commits are scheduled by edge offset from the accept edge e0.
    logic       m_w [2], m_x [2], m_y [2], m_busy [2], m_done [2], act [2];
    logic [2:0] m_z [2], m_zh [2];
    int         e0 [2];

    always @(posedge clk) begin
        n++;
        for (int i = 0; i < 2; i++) begin
            m_done[i] = 1'b0;
            if (rst) begin
                m_w[i] = 1'b1; m_x[i] = 1'b0; m_y[i] = 1'b1; m_z[i] = 3'b000;
                m_zh[i] = 3'b000; m_busy[i] = 1'b0; act[i] = 1'b0;
            end else if (act[i]) begin
                if (abort_s) begin
                    act[i] = 1'b0;
                    m_busy[i] = 1'b0;
                end else begin
                    if (n - e0[i] == DB[i]) m_x[i] = VB;
                    if (n - e0[i] == DB[i] + DC[i]) begin
                        m_y[i] = VC;
                        m_zh[i] = {m_w[i], m_x[i], m_y[i]};
                    end
                    if (n - e0[i] == DB[i] + DC[i] + DD[i]) begin
                        m_z[i] = m_zh[i];
                        m_done[i] = 1'b1;
                        m_busy[i] = 1'b0;
                        act[i] = 1'b0;
                    end
                end
            end else if (start && !abort_s) begin
                e0[i] = n;
                act[i] = 1'b1;
                m_w[i] = VA;
                m_busy[i] = 1'b1;
            end
        end
        if (rst) model_ok = 1'b1;
    end

    always @(negedge clk) begin
        if (model_ok) begin
            chk("m_a_w", aw, m_w[0]);       chk("m_b_w", bw, m_w[1]);
            chk("m_a_x", ax, m_x[0]);       chk("m_b_x", bx, m_x[1]);
            chk("m_a_y", ay, m_y[0]);       chk("m_b_y", by, m_y[1]);
            chk("m_a_z", az, m_z[0]);       chk("m_b_z", bz, m_z[1]);
            chk("m_a_busy", abusy, m_busy[0]); chk("m_b_busy", bbusy, m_busy[1]);
            chk("m_a_done", adone, m_done[0]); chk("m_b_done", bdone, m_done[1]);
        end
    end

    task automatic check_reset(input string nm);
        chk({nm, "_a_w"}, aw, 1'b1);    chk({nm, "_a_x"}, ax, 1'b0);
        chk({nm, "_a_y"}, ay, 1'b1);    chk({nm, "_a_z"}, az, 3'b000);
        chk({nm, "_a_busy"}, abusy, 1'b0); chk({nm, "_a_done"}, adone, 1'b0);
        chk({nm, "_b_busy"}, bbusy, 1'b0); chk({nm, "_b_z"}, bz, 3'b000);
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; abort_s = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_reset("rst");
    endtask

    // Default-delay timeline for instance a; px/py/pz are the values held before the run.
    task automatic run_a(input bit repulse, input int stop_k,
                         input logic px, input logic py, input logic [2:0] pz);
        start = 1'b1;
        for (int k = 0; k <= stop_k; k++) begin
            @(negedge clk);
            start = repulse && (k == 4 || k == 19);
            chk("t_a_w", aw, 1'b0);
            chk("t_a_x", ax, (k >= 10) ? 1'b1 : px);
            chk("t_a_y", ay, (k >= 15) ? 1'b0 : py);
            chk("t_a_z", az, (k >= 35) ? 3'b010 : pz);
            chk("t_a_busy", abusy, k <= 34);
            chk("t_a_done", adone, k == 35);
        end
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort_s = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_reset("t1");

        // unit delays with start held: commits at 1,2,3 and re-accept at 4
        start = 1'b1;
        for (int k = 0; k <= 5; k++) begin
            @(negedge clk);
            chk("t5_b_x", bx, k >= 1);
            chk("t5_b_y", by, k < 2);
            chk("t5_b_z", bz, (k >= 3) ? 3'b010 : 3'b000);
            chk("t5_b_done", bdone, k == 3);
            chk("t5_b_busy", bbusy, k <= 2 || k >= 4);
        end
        start = 1'b0;

        do_reset();
        run_a(1'b0, 35, 1'b0, 1'b1, 3'b000);
        run_a(1'b1, 35, 1'b1, 1'b0, 3'b010);

        do_reset();
        run_a(1'b0, 12, 1'b0, 1'b1, 3'b000);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset("t4");
        run_a(1'b0, 35, 1'b0, 1'b1, 3'b000);

`ifdef SEQ_ABORT_EN
        do_reset();
        run_a(1'b0, 14, 1'b0, 1'b1, 3'b000);
        abort_s = 1'b1;
        @(negedge clk);
        abort_s = 1'b0;
        chk("t6_a_y", ay, 1'b1);
        chk("t6_a_z", az, 3'b000);
        chk("t6_a_busy", abusy, 1'b0);
        @(negedge clk);
        chk("t6_a_busy16", abusy, 1'b0);
        repeat (25) @(negedge clk);
        chk("t6_a_z_end", az, 3'b000);
`endif

        do_reset();
        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 9) == 0) start = ~start;
`ifdef SEQ_ABORT_EN
            abort_s = ($urandom_range(0, 149) == 0);
`endif
            @(negedge clk);
        end
        rst = 1'b0; start = 1'b0; abort_s = 1'b0;
        repeat (40) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
